// File: rtl/tzn_norm_pipe.sv
// tzn_norm_pipe: pipelined trailing-zero counter and normaliser.
// Each operand yields tz = trailing-zero count and norm = a >> tz, with a
// sideband tag carried alongside. The pipeline has $clog2(WIDTH) stages and
// valid/ready on both sides; the whole pipe advances or holds as one unit.
// Optional feature: define TZN_STATS_EN to add saturating counters of accepted
// operands and accepted all-zero operands.
module tzn_norm_pipe #(
    parameter int WIDTH  = 32,
    parameter int TAG_W  = 4,
    parameter int STAT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [WIDTH-1:0]           a_i,
    input  logic [TAG_W-1:0]           tag_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(WIDTH):0]     tz_o,
    output logic [WIDTH-1:0]           norm_o,
    output logic                       zero_o,
    output logic [TAG_W-1:0]           tag_o
`ifdef TZN_STATS_EN
    ,
    output logic [STAT_W-1:0]          stat_txn_o,
    output logic [STAT_W-1:0]          stat_zero_o
`endif
);

    localparam int L  = $clog2(WIDTH);
    localparam int CW = L + 1;

    // Stage registers, index k = pipeline stage k
    logic             vld_p [L];
    logic [WIDTH-1:0] val_p [L];
    logic [CW-1:0]    cnt_p [L];
    logic [TAG_W-1:0] tag_p [L];

    // Stage inputs and the value/count each stage will capture
    logic             in_vld  [L];
    logic [WIDTH-1:0] in_val  [L];
    logic [CW-1:0]    in_cnt  [L];
    logic [TAG_W-1:0] in_tag  [L];
    logic [WIDTH-1:0] nxt_val [L];
    logic [CW-1:0]    nxt_cnt [L];

    logic adv;

    // The pipe moves whenever the output slot is empty or being consumed
    assign adv     = !vld_p[L-1] || ready_i;
    assign ready_o = adv;

    // Stage 0 takes the operand port; every later stage takes its predecessor
    always_comb begin
        in_vld[0] = valid_i;
        in_val[0] = a_i;
        in_cnt[0] = '0;
        in_tag[0] = tag_i;
        for (int k = 1; k < L; k++) begin
            in_vld[k] = vld_p[k-1];
            in_val[k] = val_p[k-1];
            in_cnt[k] = cnt_p[k-1];
            in_tag[k] = tag_p[k-1];
        end
    end

    // Binary search: stage k strips WIDTH>>(k+1) zero bits when the low half-window is clear
    always_comb begin
        for (int k = 0; k < L; k++) begin
            nxt_val[k] = in_val[k];
            nxt_cnt[k] = in_cnt[k];
            if ((in_val[k] << (WIDTH - (WIDTH >> (k + 1)))) == '0) begin
                nxt_val[k] = in_val[k] >> (WIDTH >> (k + 1));
                nxt_cnt[k] = in_cnt[k] + CW'(WIDTH >> (k + 1));
            end
        end
    end

    // Pipeline register bank: clear on reset, shift together on adv, else hold
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < L; k++) begin
                vld_p[k] <= 1'b0;
                val_p[k] <= '0;
                cnt_p[k] <= '0;
                tag_p[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < L; k++) begin
                vld_p[k] <= in_vld[k];
                val_p[k] <= nxt_val[k];
                cnt_p[k] <= nxt_cnt[k];
                tag_p[k] <= in_tag[k];
            end
        end
    end

    // Last stage drives the result; zero is qualified by valid so reset outputs read 0
    assign valid_o = vld_p[L-1];
    assign zero_o  = vld_p[L-1] && (val_p[L-1] == '0);
    assign tz_o    = zero_o ? CW'(WIDTH) : cnt_p[L-1];
    assign norm_o  = val_p[L-1];
    assign tag_o   = tag_p[L-1];

`ifdef TZN_STATS_EN
    logic [STAT_W-1:0] txn_cnt;
    logic [STAT_W-1:0] zero_cnt;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Count accepted operands (and all-zero ones), sticking at all-ones
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            txn_cnt  <= '0;
            zero_cnt <= '0;
        end else if (valid_i && adv) begin
            txn_cnt <= sat_inc(txn_cnt);
            if (a_i == '0) begin
                zero_cnt <= sat_inc(zero_cnt);
            end
        end
    end

    assign stat_txn_o  = txn_cnt;
    assign stat_zero_o = zero_cnt;
`endif

endmodule

// File: tb/tb_tzn_norm_pipe.sv
// Scoreboard bench for tzn_norm_pipe (WIDTH = 32): the driver pushes the
// hand-computed result of every accepted operand, the monitor pops and
// compares on each output transfer and checks stall stability.
module tb_tzn_norm_pipe;

    localparam int W      = 32;
    localparam int TAG_W  = 4;
    localparam int STAT_W = 16;
    localparam int L      = $clog2(W);
    localparam int CW     = L + 1;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             valid_i;
    logic             ready_o;
    logic [W-1:0]     a_i;
    logic [TAG_W-1:0] tag_i;
    logic             valid_o;
    logic             ready_i;
    logic [CW-1:0]    tz_o;
    logic [W-1:0]     norm_o;
    logic             zero_o;
    logic [TAG_W-1:0] tag_o;
`ifdef TZN_STATS_EN
    logic [STAT_W-1:0] stat_txn_o;
    logic [STAT_W-1:0] stat_zero_o;
`endif

    tzn_norm_pipe #(.WIDTH(W), .TAG_W(TAG_W), .STAT_W(STAT_W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .tag_i   (tag_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .tz_o    (tz_o),
        .norm_o  (norm_o),
        .zero_o  (zero_o),
        .tag_o   (tag_o)
`ifdef TZN_STATS_EN
        ,
        .stat_txn_o  (stat_txn_o),
        .stat_zero_o (stat_zero_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0]    tz;
        logic [W-1:0]     norm;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_txn = 0;
    int   exp_zero = 0;

    // Back-to-back stream vectors with hand-computed results
    logic [W-1:0] sv_a    [8] = '{32'h0000_0002, 32'h0000_0050, 32'h1234_5678, 32'h0001_0000,
                                  32'hA000_0000, 32'h0000_0000, 32'h0000_FF00, 32'h4000_0001};
    int           sv_tz   [8] = '{1, 4, 3, 16, 29, 32, 8, 0};
    logic [W-1:0] sv_norm [8] = '{32'h0000_0001, 32'h0000_0005, 32'h0246_8ACF, 32'h0000_0001,
                                  32'h0000_0005, 32'h0000_0000, 32'h0000_00FF, 32'h4000_0001};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Present one operand and wait until it is accepted; push its expected result
    task automatic send(input logic [W-1:0] a, input logic [TAG_W-1:0] t,
                        input int tz, input logic [W-1:0] norm);
        exp_t e;
        bit   done;
        int   guard;
        e.tz   = CW'(tz);
        e.norm = norm;
        e.zero = (tz == W);
        e.tag  = t;
        valid_i = 1'b1;
        a_i     = a;
        tag_i   = t;
        done    = 1'b0;
        guard   = 0;
        while (!done) begin
            @(negedge clk);
            if (ready_o) begin
                exp_q.push_back(e);
                exp_txn++;
                if (a == '0) exp_zero++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard > 100) begin
                check("send_timeout", 64'd0, 64'd1);
                done = 1'b1;
            end
        end
        valid_i = 1'b0;
    endtask

    // Called right after the accepting edge: edges until valid_o appears
    task automatic latency_check(input string name);
        int lat;
        lat = 0;
        while (!valid_o && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(name, 64'(lat), 64'(L - 1));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string name);
`ifdef TZN_STATS_EN
        check({name, "_txn"}, 64'(stat_txn_o), 64'(exp_txn));
        check({name, "_zero"}, 64'(stat_zero_o), 64'(exp_zero));
`else
        if (name.len() == 0) $display("unnamed stats point");
`endif
    endtask

    // Monitor: compare on every output transfer, and demand stability while stalled
    exp_t        mon_e;
    bit          hold = 1'b0;
    logic [63:0] prev_pack;
    logic [63:0] cur_pack;
    always @(negedge clk) begin
        if (rst_i) begin
            hold = 1'b0;
        end else begin
            cur_pack = 64'({valid_o, tz_o, norm_o, zero_o, tag_o});
            if (hold) check("stall_hold", cur_pack, prev_pack);
            check("ready_o", 64'(ready_o), 64'(!valid_o || ready_i));
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(tag_o), 64'hFFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tz",   64'(tz_o),   64'(mon_e.tz));
                    check("norm", 64'(norm_o), 64'(mon_e.norm));
                    check("zero", 64'(zero_o), 64'(mon_e.zero));
                    check("tag",  64'(tag_o),  64'(mon_e.tag));
                end
            end
            hold      = valid_o && !ready_i;
            prev_pack = cur_pack;
        end
    end

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        a_i     = '0;
        tag_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_tz_o",    64'(tz_o),    64'd0);
        check("rst_norm_o",  64'(norm_o),  64'd0);
        check("rst_zero_o",  64'(zero_o),  64'd0);
        check("rst_tag_o",   64'(tag_o),   64'd0);
        check("rst_ready_o", 64'(ready_o), 64'd1);
        check_stats("rst_stat");
        @(posedge clk);
        #1;

        // Single operand, latency
        send(32'h0000_0001, 4'd1, 0, 32'h0000_0001);
        latency_check("latency");
        drain();

        // Boundary operands including all-zero
        send(32'h8000_0000, 4'd2, 31, 32'h0000_0001);
        send(32'h0000_0C00, 4'd3, 10, 32'h0000_0003);
        send(32'hFFFF_FFFF, 4'd4, 0,  32'hFFFF_FFFF);
        send(32'h0000_0000, 4'd5, 32, 32'h0000_0000);
        drain();
        check_stats("stat_after_zero");

        // Back-to-back stream with a 3-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 8; i++) send(sv_a[i], TAG_W'(i + 8), sv_tz[i], sv_norm[i]);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                ready_i = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                ready_i = 1'b1;
            end
        join
        drain();

        // Reset with 3 operands in flight: they must never appear
        send(32'h0000_0010, 4'd13, 4, 32'h0000_0001);
        send(32'h0000_0300, 4'd14, 8, 32'h0000_0003);
        send(32'h0000_0007, 4'd15, 0, 32'h0000_0007);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        exp_q.delete();
        exp_txn  = 0;
        exp_zero = 0;
        check("post_rst_valid_o", 64'(valid_o), 64'd0);
        check_stats("post_rst_stat");
        repeat (8) @(posedge clk);
        #1;

        send(32'h0000_0600, 4'd6, 9, 32'h0000_0003);
        latency_check("latency_after_reset");
        drain();
        check_stats("final_stat");
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
